// File: rtl/cache_refill_controller_pkg.sv
// Shared types and helpers for the cache refill controller.
package cache_refill_controller_pkg;

  // Miss-handling phases: idle, victim writeback, line refill, tag commit.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WB     = 2'd1,
    FILL   = 2'd2,
    COMMIT = 2'd3
  } refill_state_e;

  localparam int ADDR_W      = 32;
  localparam int WORD_ADDR_W = 30;

  // Word-offset field width for a line of line_words 32-bit words.
  function automatic int calc_offset_w(input int line_words);
    return $clog2(line_words);
  endfunction

  // Tag width left over once the index and word-offset fields are taken.
  function automatic int calc_tag_w(input int index_w, input int offset_w);
    return WORD_ADDR_W - index_w - offset_w;
  endfunction

  // Byte address of word word_off within the line whose word-address base
  // (offset field zero) is line_base.
  function automatic logic [ADDR_W-1:0] compose_addr(input logic [WORD_ADDR_W-1:0] line_base,
                                                     input logic [WORD_ADDR_W-1:0] word_off);
    return {line_base | word_off, 2'b00};
  endfunction

endpackage

// File: rtl/cache_refill_controller_onehot_to_bin.sv
// Lowest-set-bit encoder: turns a (nominally one-hot) victim vector into a
// way number. Several bits set -> lowest wins; no bits set -> way 0.
module cache_refill_controller_onehot_to_bin #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     onehot_i,
  output logic [IDX_W-1:0] idx_o
);

  logic [N-1:0] w_seen;
  logic [N-1:0] w_first;

  assign w_seen[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 1; gi < N; gi++) begin : g_seen
      assign w_seen[gi] = |onehot_i[gi-1:0];
    end
    for (gi = 0; gi < N; gi++) begin : g_first
      assign w_first[gi] = onehot_i[gi] & ~w_seen[gi];
    end
  endgenerate

  // Binary index of the single isolated bit (zero when nothing is set).
  always_comb begin
    idx_o = '0;
    for (int i = 0; i < N; i++) begin
      if (w_first[i]) idx_o = idx_o | IDX_W'(i);
    end
  end

endmodule

// File: rtl/cache_refill_controller.sv
// Miss handler: latches the miss and its victim, writes the victim back when
// dirty, refills the line word by word, then commits the new tag.
module cache_refill_controller
  import cache_refill_controller_pkg::*;
#(
  parameter int SET_SIZE   = 4,
  parameter int LINE_WORDS = 4,
  parameter int INDEX_W    = 4,
  parameter int OFFSET_W   = calc_offset_w(LINE_WORDS),
  parameter int TAG_W      = calc_tag_w(INDEX_W, OFFSET_W)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                miss_i,
  input  logic [31:0]         addr_i,
  input  logic [SET_SIZE-1:0] victim_line_i,
  input  logic                victim_dirty_i,
  input  logic [TAG_W-1:0]    victim_tag_i,
  input  logic [31:0]         line_rdata_i,
  output logic [SET_SIZE-1:0] line_sel_o,
  output logic [OFFSET_W-1:0] line_offset_o,
  output logic                line_we_o,
  output logic [31:0]         line_wdata_o,
  output logic                tag_we_o,
  output logic [TAG_W-1:0]    tag_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [31:0]         mem_addr_o,
  output logic [31:0]         mem_wdata_o,
  input  logic                mem_ack_i,
  input  logic [31:0]         mem_rdata_i,
  output logic                replace_en_o,
  output logic                busy_o,
  output logic                done_o
);

  localparam int SEL_W = (SET_SIZE > 1) ? $clog2(SET_SIZE) : 1;

  refill_state_e r_state, w_state_next;

  logic [OFFSET_W-1:0] r_cnt;
  logic [TAG_W-1:0]    r_tag;
  logic [TAG_W-1:0]    r_victim_tag;
  logic [INDEX_W-1:0]  r_index;
  logic [SET_SIZE-1:0] r_line_sel;

  logic [SEL_W-1:0]       w_victim_idx;
  logic                   w_accept;
  logic                   w_xfer_ack;
  logic                   w_last_word;
  logic [WORD_ADDR_W-1:0] w_fill_base;
  logic [WORD_ADDR_W-1:0] w_wb_base;
  logic [WORD_ADDR_W-1:0] w_word_off;
  logic                   w_unused_addr;

  cache_refill_controller_onehot_to_bin #(
    .N     (SET_SIZE),
    .IDX_W (SEL_W)
  ) u_victim_enc (
    .onehot_i (victim_line_i),
    .idx_o    (w_victim_idx)
  );

  assign w_accept    = (r_state == IDLE) & miss_i;
  // An ack only counts while a bus transfer is actually being requested.
  assign w_xfer_ack  = ((r_state == WB) | (r_state == FILL)) & mem_ack_i;
  assign w_last_word = (r_cnt == OFFSET_W'(LINE_WORDS - 1));
  assign w_fill_base = {r_tag, r_index, {OFFSET_W{1'b0}}};
  assign w_wb_base   = {r_victim_tag, r_index, {OFFSET_W{1'b0}}};
  assign w_word_off  = WORD_ADDR_W'(r_cnt);
  // Byte and word-offset bits of the miss address do not select anything.
  assign w_unused_addr = ^addr_i[OFFSET_W+1:0];

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_state_next;
  end

  // Next-state: writeback only for dirty victims; phases end on the last word's ack.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (miss_i) w_state_next = victim_dirty_i ? WB : FILL;
      WB:      if (w_xfer_ack && w_last_word) w_state_next = FILL;
      FILL:    if (w_xfer_ack && w_last_word) w_state_next = COMMIT;
      COMMIT:  w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Word counter: cleared on accept, advanced per acked word, wraps between phases.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)         r_cnt <= '0;
    else if (w_accept)   r_cnt <= '0;
    else if (w_xfer_ack) r_cnt <= r_cnt + 1'b1;
  end

  // Miss context captured once at accept; later input changes are ignored.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_tag        <= '0;
      r_index      <= '0;
      r_victim_tag <= '0;
      r_line_sel   <= '0;
    end else if (w_accept) begin
      r_tag        <= addr_i[31 -: TAG_W];
      r_index      <= addr_i[OFFSET_W+2 +: INDEX_W];
      r_victim_tag <= victim_tag_i;
      r_line_sel   <= SET_SIZE'(1) << w_victim_idx;
    end
  end

  // Output decode; data paths are gated so everything idles at zero.
  always_comb begin
    line_sel_o    = r_line_sel;
    line_offset_o = r_cnt;
    tag_o         = r_tag;
    line_we_o     = 1'b0;
    line_wdata_o  = '0;
    tag_we_o      = 1'b0;
    mem_req_o     = 1'b0;
    mem_we_o      = 1'b0;
    mem_addr_o    = '0;
    mem_wdata_o   = '0;
    replace_en_o  = 1'b0;
    busy_o        = 1'b1;
    done_o        = 1'b0;
    case (r_state)
      IDLE: busy_o = 1'b0;
      WB: begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = compose_addr(w_wb_base, w_word_off);
        mem_wdata_o = line_rdata_i;
      end
      FILL: begin
        mem_req_o    = 1'b1;
        mem_addr_o   = compose_addr(w_fill_base, w_word_off);
        line_wdata_o = mem_rdata_i;
        line_we_o    = mem_ack_i;
      end
      COMMIT: begin
        tag_we_o     = 1'b1;
        replace_en_o = 1'b1;
        done_o       = 1'b1;
      end
      default: busy_o = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_cache_refill_controller.sv
// Self-checking bench for cache_refill_controller: directed and random misses
// compared against a transfer-list model of the miss sequence.
module tb_cache_refill_controller;

  localparam int SS = 4;
  localparam int LW = 4;
  localparam int IW = 4;
  localparam int OW = 2;
  localparam int TW = 24;
  localparam int TAG_SHIFT = 2 + OW + IW;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          miss_i;
  logic [31:0]   addr_i;
  logic [SS-1:0] victim_line_i;
  logic          victim_dirty_i;
  logic [TW-1:0] victim_tag_i;
  logic [31:0]   line_rdata_i;
  logic [SS-1:0] line_sel_o;
  logic [OW-1:0] line_offset_o;
  logic          line_we_o;
  logic [31:0]   line_wdata_o;
  logic          tag_we_o;
  logic [TW-1:0] tag_o;
  logic          mem_req_o;
  logic          mem_we_o;
  logic [31:0]   mem_addr_o;
  logic [31:0]   mem_wdata_o;
  logic          mem_ack_i;
  logic [31:0]   mem_rdata_i;
  logic          replace_en_o;
  logic          busy_o;
  logic          done_o;

  cache_refill_controller #(
    .SET_SIZE   (SS),
    .LINE_WORDS (LW),
    .INDEX_W    (IW)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .miss_i         (miss_i),
    .addr_i         (addr_i),
    .victim_line_i  (victim_line_i),
    .victim_dirty_i (victim_dirty_i),
    .victim_tag_i   (victim_tag_i),
    .line_rdata_i   (line_rdata_i),
    .line_sel_o     (line_sel_o),
    .line_offset_o  (line_offset_o),
    .line_we_o      (line_we_o),
    .line_wdata_o   (line_wdata_o),
    .tag_we_o       (tag_we_o),
    .tag_o          (tag_o),
    .mem_req_o      (mem_req_o),
    .mem_we_o       (mem_we_o),
    .mem_addr_o     (mem_addr_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_ack_i      (mem_ack_i),
    .mem_rdata_i    (mem_rdata_i),
    .replace_en_o   (replace_en_o),
    .busy_o         (busy_o),
    .done_o         (done_o)
  );

  always #5 clk_i = ~clk_i;

  // Victim line contents as seen by the asynchronous array read.
  logic [31:0] line_mem [LW];
  assign line_rdata_i = line_mem[line_offset_o];

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          stall;
  } xfer_t;

  xfer_t q[$];
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, 32'({busy_o, done_o, tag_we_o, replace_en_o, mem_req_o, mem_we_o, line_we_o}), 32'd0);
    chk({tag, "_addr"}, mem_addr_o, 32'd0);
    chk({tag, "_wdata"}, mem_wdata_o, 32'd0);
    chk({tag, "_lwdata"}, line_wdata_o, 32'd0);
    chk({tag, "_sel_off_tag"}, 32'({line_sel_o, line_offset_o, tag_o}), 32'd0);
  endtask

  // Lowest set bit of the victim vector; an empty vector means way 0.
  function automatic logic [31:0] exp_sel(input logic [SS-1:0] v);
    logic [SS-1:0] t;
    if (v == '0) return 32'd1;
    t = v & (~v + 1'b1);
    return 32'(t);
  endfunction

  // Expected bus transfers: dirty victims write their whole line back at the
  // victim's own tag, then the missing line is read from its aligned base.
  task automatic build_plan(input logic [31:0] addr, input logic dirty, input logic [31:0] vtag,
                            input int stall_word, input int stall_max, output int total_stall);
    logic [31:0] index_bits, fill_base, wb_base;
    xfer_t x;
    index_bits  = addr & ((32'd1 << TAG_SHIFT) - 32'd1) & ~32'(LW * 4 - 1);
    fill_base   = addr & ~32'(LW * 4 - 1);
    wb_base     = (vtag << TAG_SHIFT) | index_bits;
    total_stall = 0;
    q.delete();
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 0 && !dirty) continue;
      for (int i = 0; i < LW; i++) begin
        x.we    = (pass == 0);
        x.addr  = ((pass == 0) ? wb_base : fill_base) + 32'(4 * i);
        x.wdata = (pass == 0) ? line_mem[i] : 32'd0;
        if (stall_word >= 0) x.stall = (pass == 1 && i == stall_word) ? 3 : 0;
        else                 x.stall = $urandom_range(0, stall_max);
        total_stall += x.stall;
        q.push_back(x);
      end
    end
  endtask

  // Called just after a rising edge with the DUT idle; returns the same way.
  task automatic run_miss(input string name, input logic [31:0] addr, input logic [SS-1:0] victim,
                          input logic dirty, input logic [31:0] vtag,
                          input int stall_word, input int stall_max, input bit hold);
    int cyc, stall_left, total_stall, exp_cyc;
    bit finished;
    logic [31:0] word;
    for (int i = 0; i < LW; i++) line_mem[i] = $urandom;
    build_plan(addr, dirty, vtag, stall_word, stall_max, total_stall);
    exp_cyc        = 2 + LW * (dirty ? 2 : 1) + total_stall;
    miss_i         = 1'b1;
    addr_i         = addr;
    victim_line_i  = victim;
    victim_dirty_i = dirty;
    victim_tag_i   = vtag[TW-1:0];
    mem_ack_i      = 1'($urandom_range(0, 1));
    mem_rdata_i    = $urandom;
    stall_left     = q[0].stall;
    cyc            = 0;
    finished       = 0;
    while (!finished && cyc < 200) begin
      @(negedge clk_i);
      cyc++;
      chk({name, "_busy"}, 32'(busy_o), 32'(cyc > 1));
      if (q.size() == 0) begin
        chk({name, "_commit"}, 32'({tag_we_o, replace_en_o, done_o, mem_req_o}), 32'b1110);
        chk({name, "_tag"}, 32'(tag_o), addr >> TAG_SHIFT);
        chk({name, "_line_sel"}, 32'(line_sel_o), exp_sel(victim));
        chk({name, "_latency"}, 32'(cyc), 32'(exp_cyc));
        finished = 1;
      end else begin
        chk({name, "_no_commit"}, 32'({tag_we_o, replace_en_o, done_o}), 32'd0);
        if (cyc == 1) begin
          chk({name, "_idle_req"}, 32'(mem_req_o), 32'd0);
        end else begin
          word = (q[0].addr >> 2) % LW;
          chk({name, "_req"}, 32'(mem_req_o), 32'd1);
          chk({name, "_we"}, 32'(mem_we_o), 32'(q[0].we));
          chk({name, "_addr"}, mem_addr_o, q[0].addr);
          chk({name, "_offset"}, 32'(line_offset_o), word);
          if (q[0].we) chk({name, "_wdata"}, mem_wdata_o, q[0].wdata);
          if (mem_ack_i) begin
            chk({name, "_line_we"}, 32'(line_we_o), 32'(!q[0].we));
            if (!q[0].we) chk({name, "_line_wdata"}, line_wdata_o, mem_rdata_i);
            $display("%s word addr=%h we=%0d", name, q[0].addr, q[0].we);
            void'(q.pop_front());
            if (q.size() != 0) stall_left = q[0].stall;
          end else begin
            chk({name, "_line_we_stall"}, 32'(line_we_o), 32'd0);
          end
        end
      end
      if (!finished) begin
        @(posedge clk_i);
        #1;
        if (hold) begin
          addr_i         = $urandom;
          victim_line_i  = SS'($urandom);
          victim_dirty_i = 1'($urandom);
          victim_tag_i   = TW'($urandom);
        end else begin
          miss_i = 1'b0;
        end
        mem_rdata_i = $urandom;
        if (mem_req_o) begin
          if (stall_left > 0) begin
            mem_ack_i = 1'b0;
            stall_left--;
          end else begin
            mem_ack_i = 1'b1;
          end
        end else begin
          mem_ack_i = 1'($urandom_range(0, 1));
        end
      end
    end
    if (!finished) chk({name, "_timeout"}, 32'd0, 32'd1);
    @(posedge clk_i);
    #1;
    miss_i    = 1'b0;
    mem_ack_i = 1'b0;
    @(negedge clk_i);
    chk({name, "_idle_after"}, 32'({busy_o, done_o, tag_we_o, mem_req_o}), 32'd0);
    $display("%s done addr=%h victim=%b dirty=%0d cycles=%0d", name, addr, victim, dirty, cyc);
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] raddr, rvtag, exp_wb1;
    rst_ni         = 1'b0;
    miss_i         = 1'b0;
    addr_i         = '0;
    victim_line_i  = '0;
    victim_dirty_i = 1'b0;
    victim_tag_i   = '0;
    mem_ack_i      = 1'b0;
    mem_rdata_i    = 32'hDEAD_BEEF;
    for (int i = 0; i < LW; i++) line_mem[i] = $urandom;
    #1;
    chk_all_zero("reset");
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    run_miss("clean", 32'h0000_1230, 4'b0100, 1'b0, 32'h0, -1, 0, 1'b0);
    run_miss("dirty", 32'hABCD_5670, 4'b0110, 1'b1, 32'h3FF, -1, 0, 1'b0);
    run_miss("stall", 32'h0000_2340, 4'b0000, 1'b0, 32'h0, 2, 0, 1'b0);
    run_miss("busy_miss", 32'h0000_1230, 4'b1000, 1'b0, 32'h0, -1, 0, 1'b1);

    // Reset while the second writeback word is on the bus.
    raddr = 32'h0000_5670;
    rvtag = 32'h00AB_CDEF;
    exp_wb1 = (rvtag << TAG_SHIFT) | 32'h70 | 32'h4;
    for (int i = 0; i < LW; i++) line_mem[i] = $urandom;
    miss_i = 1'b1; addr_i = raddr; victim_line_i = 4'b0001;
    victim_dirty_i = 1'b1; victim_tag_i = rvtag[TW-1:0]; mem_ack_i = 1'b0;
    @(posedge clk_i); #1;
    miss_i = 1'b0; mem_ack_i = 1'b1;
    @(posedge clk_i); #1;
    chk("rst_wb1_addr", mem_addr_o, exp_wb1);
    chk("rst_wb1_data", mem_wdata_o, line_mem[1]);
    rst_ni = 1'b0;
    #1;
    chk_all_zero("midop_reset");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("rst_hold", 32'({tag_we_o, replace_en_o, done_o, busy_o}), 32'd0);
    end
    rst_ni = 1'b1;
    mem_ack_i = 1'b0;
    @(posedge clk_i); #1;
    chk("rst_release_idle", 32'({busy_o, mem_req_o, tag_we_o}), 32'd0);
    $display("midop_reset done addr=%h", raddr);

    run_miss("after_reset", 32'h0000_0FF0, 4'b0010, 1'b1, 32'h12, -1, 1, 1'b0);

    for (int n = 0; n < 20; n++) begin
      run_miss("rand", $urandom, SS'($urandom), 1'($urandom), 32'($urandom & ((1 << TW) - 1)),
               -1, 2, 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
